// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared constants and types for the modulo-N counter
//
// Purpose : mode/direction constants, per-edge action type and a helper
//           that sizes the prescaler phase register.
// Ports   : none (package).
package contador_pkg;

  // SATURAR parameter values
  localparam int MODO_CICLICO  = 0;
  localparam int MODO_SATURADO = 1;

  // i_sentido values
  localparam logic SUBIR = 1'b1;
  localparam logic BAJAR = 1'b0;

  // What the counter does on a given edge, in priority order
  typedef enum logic [1:0] {
    ACC_MANTENER = 2'd0,
    ACC_LIMPIAR  = 2'd1,
    ACC_CARGAR   = 2'd2,
    ACC_PASO     = 2'd3
  } accion_e;

  // Phase register width; a ratio of 1 still gets a 1-bit register
  function automatic int ancho_divisor(input int divisor);
    return (divisor > 1) ? $clog2(divisor) : 1;
  endfunction

endpackage

// File: rtl/contador_divisor.sv
// rtl/contador_divisor.sv - enable prescaler producing a step strobe every DIVISOR enabled cycles
//
// Purpose : counts enabled cycles 0..DIVISOR-1; the strobe marks the cycle in
//           which the phase sits at DIVISOR-1 while enabled.
// Ports   : i_clk       clock, rising edge
//           i_rst_n     asynchronous active-low reset
//           i_habilitar advance the phase
//           i_limpiar   synchronous clear of the phase
//           o_tick      step strobe for the current cycle (the parent registers
//                       it and uses it to decide the step on the same edge)
module contador_divisor
  import contador_pkg::*;
#(
  parameter int DIVISOR = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_habilitar,
  input  logic i_limpiar,
  output logic o_tick
);

  localparam int               W      = ancho_divisor(DIVISOR);
  localparam logic [W-1:0]     ULTIMO = W'(DIVISOR - 1);

  logic [W-1:0] fase_q;
  logic [W-1:0] fase_d;

  always_comb begin
    fase_d = fase_q;
    if (i_limpiar) begin
      fase_d = '0;
    end else if (i_habilitar) begin
      fase_d = (fase_q == ULTIMO) ? '0 : fase_q + W'(1);
    end
  end

  // With DIVISOR=1 ULTIMO is 0 and the phase never leaves 0, so the
  // strobe simply follows the enable.
  assign o_tick = i_habilitar & ~i_limpiar & (fase_q == ULTIMO);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fase_q <= '0;
    end else begin
      fase_q <= fase_d;
    end
  end

endmodule

// File: rtl/contador_modulo_n.sv
// rtl/contador_modulo_n.sv - up/down modulo-N counter with prescaler, load, clear and saturation
//
// Purpose : counts 0..MODULO-1 one step per prescaler tick, wrapping or
//           holding at the limits; all outputs come straight from registers.
// Ports   : i_clk       clock, rising edge
//           i_rst_n     asynchronous active-low reset
//           i_habilitar count enable (feeds the prescaler)
//           i_sentido   1 = up, 0 = down
//           i_cargar    synchronous load of i_valor (clamped to MODULO-1)
//           i_valor     load value
//           i_limpiar   synchronous clear (highest priority)
//           o_cuenta    registered count
//           o_fin       one-cycle pulse with a step taken from a limit
//           o_tick      registered prescaler tick, aligned with the step it caused
module contador_modulo_n
  import contador_pkg::*;
#(
  parameter int ANCHO   = 4,
  parameter int MODULO  = 11,
  parameter int DIVISOR = 1,
  parameter int SATURAR = MODO_CICLICO
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_habilitar,
  input  logic             i_sentido,
  input  logic             i_cargar,
  input  logic [ANCHO-1:0] i_valor,
  input  logic             i_limpiar,
  output logic [ANCHO-1:0] o_cuenta,
  output logic             o_fin,
  output logic             o_tick
);

  if (MODULO < 2 || MODULO > (2 ** ANCHO) || DIVISOR < 1) begin : g_param_invalido
    $error("contador_modulo_n: need 2 <= MODULO <= 2**ANCHO and DIVISOR >= 1");
  end

  // One extra bit so MODULO = 2**ANCHO and clamping compare without overflow
  localparam int               AW         = ANCHO + 1;
  localparam logic [AW-1:0]    MODULO_EXT = AW'(MODULO);
  localparam logic [ANCHO-1:0] LIMITE     = ANCHO'(MODULO - 1);
  localparam logic             SAT        = (SATURAR == MODO_SATURADO);

  logic [ANCHO-1:0] cuenta_q, cuenta_d;
  logic             fin_q, fin_d;
  logic             tick_q, tick_d;
  logic             tick_div;
  logic [AW-1:0]    cuenta_ext;
  logic [AW-1:0]    valor_ext;
  accion_e          accion;

  contador_divisor #(
    .DIVISOR(DIVISOR)
  ) u_divisor (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_habilitar(i_habilitar),
    .i_limpiar  (i_limpiar),
    .o_tick     (tick_div)
  );

  assign cuenta_ext = {1'b0, cuenta_q};
  assign valor_ext  = {1'b0, i_valor};

  always_comb begin
    accion = ACC_MANTENER;
    if (i_limpiar) begin
      accion = ACC_LIMPIAR;
    end else if (i_cargar) begin
      accion = ACC_CARGAR;
    end else if (tick_div) begin
      accion = ACC_PASO;
    end
  end

  always_comb begin
    cuenta_d = cuenta_q;
    fin_d    = 1'b0;
    tick_d   = tick_div;
    case (accion)
      ACC_LIMPIAR: begin
        cuenta_d = '0;
        tick_d   = 1'b0;
      end
      ACC_CARGAR: begin
        cuenta_d = (valor_ext >= MODULO_EXT) ? LIMITE : i_valor;
      end
      ACC_PASO: begin
        if (i_sentido == SUBIR) begin
          if (cuenta_q == LIMITE) begin
            fin_d    = 1'b1;
            cuenta_d = SAT ? LIMITE : '0;
          end else begin
            cuenta_d = ANCHO'(cuenta_ext + AW'(1));
          end
        end else begin
          if (cuenta_q == '0) begin
            fin_d    = 1'b1;
            cuenta_d = SAT ? '0 : LIMITE;
          end else begin
            cuenta_d = ANCHO'(cuenta_ext - AW'(1));
          end
        end
      end
      default: begin
        cuenta_d = cuenta_q;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cuenta_q <= '0;
      fin_q    <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cuenta_q <= cuenta_d;
      fin_q    <= fin_d;
      tick_q   <= tick_d;
    end
  end

  assign o_cuenta = cuenta_q;
  assign o_fin    = fin_q;
  assign o_tick   = tick_q;

endmodule

// File: tb/tb_contador_modulo_n.sv
// tb/tb_contador_modulo_n.sv - self-checking bench for contador_modulo_n
module tb_contador_modulo_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hab = 1'b0;
  logic       sent = 1'b1;
  logic       car = 1'b0;
  logic [3:0] valor = 4'd0;
  logic       lim = 1'b0;

  logic [3:0] cta [3];
  logic       fin [3];
  logic       tck [3];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: saturating, 2: DIVISOR=3
  contador_modulo_n u_def (
    .i_clk(clk), .i_rst_n(rst_n), .i_habilitar(hab), .i_sentido(sent),
    .i_cargar(car), .i_valor(valor), .i_limpiar(lim),
    .o_cuenta(cta[0]), .o_fin(fin[0]), .o_tick(tck[0]));

  contador_modulo_n #(.SATURAR(1)) u_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_habilitar(hab), .i_sentido(sent),
    .i_cargar(car), .i_valor(valor), .i_limpiar(lim),
    .o_cuenta(cta[1]), .o_fin(fin[1]), .o_tick(tck[1]));

  contador_modulo_n #(.DIVISOR(3)) u_div (
    .i_clk(clk), .i_rst_n(rst_n), .i_habilitar(hab), .i_sentido(sent),
    .i_cargar(car), .i_valor(valor), .i_limpiar(lim),
    .o_cuenta(cta[2]), .o_fin(fin[2]), .o_tick(tck[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: counts of enabled cycles and modular arithmetic
  int mod_m [3] = '{11, 11, 11};
  int div_m [3] = '{1, 1, 3};
  int sat_m [3] = '{0, 1, 0};
  int m_cta [3] = '{0, 0, 0};
  int m_ph  [3] = '{0, 0, 0};
  int m_fin [3] = '{0, 0, 0};
  int m_tck [3] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_cta[i] = 0; m_ph[i] = 0; m_fin[i] = 0; m_tck[i] = 0;
      end else if (lim) begin
        m_cta[i] = 0; m_ph[i] = 0; m_fin[i] = 0; m_tck[i] = 0;
      end else begin
        int t;
        t = (hab && m_ph[i] == div_m[i] - 1) ? 1 : 0;
        if (hab) m_ph[i] = (m_ph[i] + 1) % div_m[i];
        m_tck[i] = t;
        m_fin[i] = 0;
        if (car) begin
          m_cta[i] = (int'(valor) > mod_m[i] - 1) ? mod_m[i] - 1 : int'(valor);
        end else if (t == 1) begin
          if (sent) begin
            m_fin[i] = (m_cta[i] == mod_m[i] - 1) ? 1 : 0;
            if (sat_m[i] == 1) m_cta[i] = (m_cta[i] + 1 > mod_m[i] - 1) ? mod_m[i] - 1 : m_cta[i] + 1;
            else               m_cta[i] = (m_cta[i] + 1) % mod_m[i];
          end else begin
            m_fin[i] = (m_cta[i] == 0) ? 1 : 0;
            if (sat_m[i] == 1) m_cta[i] = (m_cta[i] - 1 < 0) ? 0 : m_cta[i] - 1;
            else               m_cta[i] = (m_cta[i] + mod_m[i] - 1) % mod_m[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model cuenta[%0d]", i), 32'(cta[i]), 32'(m_cta[i]));
      chk($sformatf("model fin[%0d]", i),    32'(fin[i]), 32'(m_fin[i]));
      chk($sformatf("model tick[%0d]", i),   32'(tck[i]), 32'(m_tck[i]));
    end
  end

  int seq_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 1};
  int dn_def [3]  = '{0, 10, 9};
  int dn_dfn [3]  = '{0, 1, 0};
  int dn_sfn [3]  = '{0, 1, 1};
  int dv_cta [4]  = '{0, 0, 1, 1};
  int dv_tck [4]  = '{0, 0, 1, 0};
  int fl_sen [4]  = '{1, 0, 1, 0};
  int fl_cta [4]  = '{6, 5, 6, 5};

  initial begin
    repeat (2) @(negedge clk);
    chk("reset cuenta", 32'(cta[0]), 32'd0);
    chk("reset tick", 32'(tck[2]), 32'd0);

    // free-running up count through the wrap
    rst_n = 1'b1; hab = 1'b1; sent = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("up cuenta k=%0d", k), 32'(cta[0]), 32'(seq_up[k]));
      chk($sformatf("up fin k=%0d", k), 32'(fin[0]), (k == 10) ? 32'd1 : 32'd0);
    end

    // down from 1: wrap vs hold at 0
    hab = 1'b0; lim = 1'b1;
    @(negedge clk);
    lim = 1'b0; car = 1'b1; valor = 4'd1;
    @(negedge clk);
    car = 1'b0; hab = 1'b1; sent = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("down cuenta k=%0d", k), 32'(cta[0]), 32'(dn_def[k]));
      chk($sformatf("down fin k=%0d", k), 32'(fin[0]), 32'(dn_dfn[k]));
      chk($sformatf("sat cuenta k=%0d", k), 32'(cta[1]), 32'd0);
      chk($sformatf("sat fin k=%0d", k), 32'(fin[1]), 32'(dn_sfn[k]));
    end

    // prescaler by 3, with the phase frozen while disabled
    hab = 1'b0; lim = 1'b1;
    @(negedge clk);
    lim = 1'b0; hab = 1'b1; sent = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("div cuenta k=%0d", k), 32'(cta[2]), 32'(dv_cta[k]));
      chk($sformatf("div tick k=%0d", k), 32'(tck[2]), 32'(dv_tck[k]));
    end
    hab = 1'b0;
    repeat (2) @(negedge clk);
    chk("div frozen cuenta", 32'(cta[2]), 32'd1);
    hab = 1'b1;
    @(negedge clk);
    chk("div resume cuenta", 32'(cta[2]), 32'd1);
    @(negedge clk);
    chk("div resume cuenta2", 32'(cta[2]), 32'd2);
    chk("div resume tick", 32'(tck[2]), 32'd1);

    // load, clamped load, clear beats load
    hab = 1'b0; car = 1'b1; valor = 4'd7;
    @(negedge clk);
    chk("load 7", 32'(cta[0]), 32'd7);
    valor = 4'd15;
    @(negedge clk);
    chk("load 15 clamp", 32'(cta[0]), 32'd10);
    chk("load fin", 32'(fin[0]), 32'd0);
    lim = 1'b1;
    @(negedge clk);
    chk("clear over load", 32'(cta[0]), 32'd0);
    lim = 1'b0; car = 1'b0;

    // asynchronous reset mid-cycle
    car = 1'b1; valor = 4'd6;
    @(negedge clk);
    car = 1'b0;
    chk("pre-reset cuenta", 32'(cta[0]), 32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset def", 32'(cta[0]), 32'd0);
    chk("async reset div", 32'(cta[2]), 32'd6 - 32'd6);
    @(negedge clk);
    rst_n = 1'b1; hab = 1'b1; sent = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post-reset div k=%0d", k), 32'(cta[2]), (k == 2) ? 32'd1 : 32'd0);
      chk($sformatf("post-reset def k=%0d", k), 32'(cta[0]), 32'(k + 1));
    end

    // direction flipped on every step
    car = 1'b1; valor = 4'd5;
    @(negedge clk);
    car = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sent = fl_sen[k][0];
      @(negedge clk);
      chk($sformatf("flip cuenta k=%0d", k), 32'(cta[0]), 32'(fl_cta[k]));
      chk($sformatf("flip fin k=%0d", k), 32'(fin[0]), 32'd0);
    end

    // disabled: everything holds, no pulses
    hab = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle cuenta", 32'(cta[0]), 32'd5);
    chk("idle tick", 32'(tck[0]), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
